vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA timing generator with blanked, registered RGB.
// Ports:
//   clk                         system clock, rising edge
//   rst_n                       synchronous active-low reset
//   red_in/green_in/blue_in     colour from game block for current x_crd/y_crd
//   x_crd/y_crd                 current horizontal/vertical counters
//   video_on                    combinational visible-area flag for x_crd/y_crd
//   hsync/vsync                 registered active-low syncs
//   red_out/green_out/blue_out  registered blanked colour
//   frame_tick                  one-clk pulse when counters wrap to (0,0)
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       red_in,
  input  logic       green_in,
  input  logic       blue_in,
  output logic [9:0] x_crd,
  output logic [9:0] y_crd,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       red_out,
  output logic       green_out,
  output logic       blue_out,
  output logic       frame_tick
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             red_q, red_d;
  logic             green_q, green_d;
  logic             blue_q, blue_d;
  logic             frame_tick_q, frame_tick_d;

  logic pix_en;
  logic h_last;
  logic v_last;
  logic vis;
  logic hs_raw;
  logic vs_raw;

  // Pixel enable, counter advance and sync/colour decode on pre-increment counters.
  always_comb begin
    pix_en       = (div_q == DIV_W'(CLK_DIV - 1));
    h_last       = (h_cnt_q == CNT_W'(H_TOTAL - 1));
    v_last       = (v_cnt_q == CNT_W'(V_TOTAL - 1));
    vis          = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
    hs_raw       = !((h_cnt_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                     (h_cnt_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    vs_raw       = !((v_cnt_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                     (v_cnt_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));

    div_d        = pix_en ? '0 : div_q + DIV_W'(1);
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;
    frame_tick_d = 1'b0;

    if (pix_en) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
      // Sync and colour for the current pixel are emitted together, one pixel late.
      hsync_d      = hs_raw;
      vsync_d      = vs_raw;
      red_d        = red_in & vis;
      green_d      = green_in & vis;
      blue_d       = blue_in & vis;
      frame_tick_d = h_last & v_last;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q        <= '0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      red_q        <= 1'b0;
      green_q      <= 1'b0;
      blue_q       <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign x_crd      = h_cnt_q;
  assign y_crd      = v_cnt_q;
  assign video_on   = vis;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign red_out    = red_q;
  assign green_out  = green_q;
  assign blue_out   = blue_q;
  assign frame_tick = frame_tick_q;

endmodule
